// File: rtl/ex_stage_pkg.sv
// Shared decode/execute definitions: operation codes, result classes and helpers
// used by the decode and execute stages.
package ex_stage_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    // Result classes (alusel)
    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_MOVE  = 3'd3;
    localparam logic [2:0] SEL_ARITH = 3'd4;
    localparam logic [2:0] SEL_MUL   = 3'd5;

    // Operation codes (aluop)
    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_SLTI  = 8'b0101_0111;
    localparam logic [7:0] OP_SLTIU = 8'b0101_1000;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
    localparam logic [7:0] OP_ADDIU = 8'b0101_0110;
    localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
    localparam logic [7:0] OP_CLO   = 8'b1011_0001;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_MUL   = 8'b1010_1001;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Leading-zero count; yields 32 for an all-zero word.
    function automatic logic [5:0] clz32(input logic [31:0] x);
        logic [5:0] n;
        logic       found;
        n     = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && x[i]) begin
                n     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ex_stage_mult.sv
// Iterative 32x32 shift-add multiplier: magnitudes and sign captured on start,
// 32 iterations in BUSY, sign-corrected product presented while in DONE.
module mult_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    mul_state_t  state_reg, state_next;
    logic [63:0] mcand_reg;
    logic [63:0] acc_reg;
    logic [31:0] mplier_reg;
    logic [4:0]  count_reg;
    logic        neg_reg;
    logic [31:0] a_mag, b_mag;

    assign a_mag = (signed_op && a[31]) ? (32'd0 - a) : a;
    assign b_mag = (signed_op && b[31]) ? (32'd0 - b) : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= MUL_IDLE;
            mcand_reg  <= 64'd0;
            acc_reg    <= 64'd0;
            mplier_reg <= 32'd0;
            count_reg  <= 5'd0;
            neg_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                MUL_IDLE: begin
                    if (start) begin
                        mcand_reg  <= {32'd0, a_mag};
                        mplier_reg <= b_mag;
                        acc_reg    <= 64'd0;
                        count_reg  <= 5'd0;
                        neg_reg    <= signed_op & (a[31] ^ b[31]);
                    end
                end
                MUL_BUSY: begin
                    if (mplier_reg[0])
                        acc_reg <= acc_reg + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            MUL_IDLE: if (start) state_next = MUL_BUSY;
            MUL_BUSY: begin
                busy = 1'b1;
                if (count_reg == 5'd31)
                    state_next = MUL_DONE;
            end
            MUL_DONE: begin
                done       = 1'b1;
                state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    assign product = neg_reg ? (64'd0 - acc_reg) : acc_reg;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU result mux, HI/LO registers and the stall
// handshake around the iterative multiplier.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic [31:0] hi_reg, lo_reg;
    logic [31:0] result;
    logic        wreg_next;
    logic [31:0] sum, diff;
    logic        add_ovf, sub_ovf;
    logic        is_mult_op, is_hilo_mult, mul_start;
    logic        mul_busy, mul_done;
    logic [63:0] product;

    assign is_mult_op   = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU) || (aluop_i == OP_MUL);
    assign is_hilo_mult = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
    assign mul_start    = is_mult_op && !mul_busy && !mul_done;

    mult_iter u_mult (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .signed_op(aluop_i != OP_MULTU),
        .a        (reg1_i),
        .b        (reg2_i),
        .busy     (mul_busy),
        .done     (mul_done),
        .product  (product)
    );

    assign sum     = reg1_i + reg2_i;
    assign diff    = reg1_i - reg2_i;
    assign add_ovf = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    assign sub_ovf = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);

    always_comb begin
        result = ZERO_WORD;
        case (alusel_i)
            SEL_LOGIC: case (aluop_i)
                OP_OR:   result = reg1_i | reg2_i;
                OP_AND:  result = reg1_i & reg2_i;
                OP_XOR:  result = reg1_i ^ reg2_i;
                OP_NOR:  result = ~(reg1_i | reg2_i);
                default: result = ZERO_WORD;
            endcase
            SEL_SHIFT: case (aluop_i)
                OP_SLL:  result = reg2_i << reg1_i[4:0];
                OP_SRL:  result = reg2_i >> reg1_i[4:0];
                OP_SRA:  result = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
                default: result = ZERO_WORD;
            endcase
            SEL_MOVE: case (aluop_i)
                OP_MFHI:          result = hi_reg;
                OP_MFLO:          result = lo_reg;
                OP_MOVN, OP_MOVZ: result = reg1_i;
                default:          result = ZERO_WORD;
            endcase
            SEL_ARITH: case (aluop_i)
                OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: result = sum;
                OP_SUB, OP_SUBU:                    result = diff;
                OP_SLT, OP_SLTI:   result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                OP_SLTU, OP_SLTIU: result = {31'd0, reg1_i < reg2_i};
                OP_CLZ:            result = {26'd0, clz32(reg1_i)};
                OP_CLO:            result = {26'd0, clz32(~reg1_i)};
                default:           result = ZERO_WORD;
            endcase
            SEL_MUL: if (aluop_i == OP_MUL && mul_done) result = product[31:0];
            default: result = ZERO_WORD;
        endcase
    end

    // Write suppression: signed overflow, HI/LO moves, and multiplies until DONE.
    always_comb begin
        wreg_next = wreg_i;
        if (((aluop_i == OP_ADD || aluop_i == OP_ADDI) && add_ovf) ||
            (aluop_i == OP_SUB && sub_ovf))
            wreg_next = 1'b0;
        if (aluop_i == OP_MTHI || aluop_i == OP_MTLO)
            wreg_next = 1'b0;
        if (is_mult_op && (!mul_done || aluop_i != OP_MUL))
            wreg_next = 1'b0;
        if (rst)
            wreg_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg <= ZERO_WORD;
            lo_reg <= ZERO_WORD;
        end else if (mul_done && is_hilo_mult) begin
            hi_reg <= product[63:32];
            lo_reg <= product[31:0];
        end else if (aluop_i == OP_MTHI) begin
            hi_reg <= reg1_i;
        end else if (aluop_i == OP_MTLO) begin
            lo_reg <= reg1_i;
        end
    end

    assign wd_o       = rst ? NOP_REG_ADDR : wd_i;
    assign wreg_o     = wreg_next;
    assign wdata_o    = rst ? ZERO_WORD : result;
    assign hi_o       = hi_reg;
    assign lo_o       = lo_reg;
    assign stallreq_o = !rst && (mul_start || mul_busy);

endmodule
